// File: rtl/ddr3_vpi_chn_wr_ctrl.sv
// VPI write channel: drains complete lines from a ping-pong line RAM into DDR3,
// one request/data/done handshake per line, tracking the row and frame being written.
module ddr3_vpi_chn_wr_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 27
) (
    input  logic                  i_sclk,
    input  logic                  i_rst_n,
    input  logic                  i_soft_rst,
    input  logic                  i_syn_v,
    input  logic                  i_line_rdy,
    input  logic                  i_line_bank,
    input  logic [3:0]            i_sub_space_num,
    input  logic [11:0]           i_write_numb,
    input  logic [11:0]           i_start_row_line,
    output logic                  o_ram_rd_en,
    output logic [7:0]            o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic                  o_ddr_vpi_req,
    input  logic                  i_ddr_vpi_ack,
    output logic [ADDR_WIDTH-1:0] o_ddr_vpi_start_addr,
    output logic [11:0]           o_ddr_vpi_data_length,
    input  logic                  i_ddr_vpi_prio_ini_vld,
    input  logic [15:0]           i_ddr_vpi_prio_ini,
    output logic [15:0]           o_ddr_vpi_priority,
    input  logic                  i_ddr_vpi_wdata_req,
    output logic [DATA_WIDTH-1:0] o_ddr_vpi_wdata,
    input  logic                  i_ddr_vpi_end,
    output logic [1:0]            o_frame_numb,
    output logic                  o_ddr_req_lose
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_END} state_t;

    state_t      state, state_nxt;
    logic        launch, use_pend;
    logic        syn_v_d, syn_rise, line_ok, pend_live;
    logic        pend_vld, pend_bank, bank_r, stale;
    logic [11:0] pend_numb, numb_r, beat_cnt;
    logic [10:0] row, row_nxt;
    logic [1:0]  frame, frame_nxt;
    logic [15:0] prio_base;
    logic        unused_start_row;

    assign unused_start_row = i_start_row_line[11];
    assign syn_rise  = i_syn_v & ~syn_v_d;
    assign line_ok   = i_line_rdy && (i_write_numb != 12'd0);
    // A frame start discards the queued line, so it can no longer be launched
    assign pend_live = pend_vld & ~syn_rise;

    assign o_ram_rd_en     = (state == DATA) && i_ddr_vpi_wdata_req;
    assign o_ram_rd_addr   = o_ram_rd_en ? {bank_r, beat_cnt[6:0]} : 8'd0;
    assign o_ddr_vpi_wdata = i_ram_rd_data;
    assign o_frame_numb    = frame;

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n)        state <= IDLE;
        else if (i_soft_rst) state <= IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        use_pend  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_live) begin
                    launch   = 1'b1;
                    use_pend = 1'b1;
                end else if (line_ok) begin
                    launch = 1'b1;
                end
            end
            REQ:  if (i_ddr_vpi_ack) state_nxt = DATA;
            DATA: if (i_ddr_vpi_wdata_req && (beat_cnt == numb_r - 12'd1)) state_nxt = WAIT_END;
            WAIT_END: begin
                if (i_ddr_vpi_end) begin
                    if (pend_live) begin
                        launch   = 1'b1;
                        use_pend = 1'b1;
                    end else if (line_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (launch) state_nxt = REQ;
    end

    // A burst that straddles a frame start belongs to the old frame and must not advance the new row
    always_comb begin
        row_nxt   = row;
        frame_nxt = frame;
        if (syn_rise) begin
            row_nxt   = i_start_row_line[10:0];
            frame_nxt = frame + 2'd1;
        end else if ((state == WAIT_END) && i_ddr_vpi_end && !stale) begin
            row_nxt = row + 11'd1;
        end
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n || i_soft_rst) begin
            syn_v_d               <= 1'b0;
            pend_vld              <= 1'b0;
            pend_bank             <= 1'b0;
            pend_numb             <= 12'd0;
            bank_r                <= 1'b0;
            numb_r                <= 12'd0;
            beat_cnt              <= 12'd0;
            stale                 <= 1'b0;
            row                   <= 11'd0;
            frame                 <= 2'd0;
            prio_base             <= 16'h0000;
            o_ddr_vpi_priority    <= 16'h0000;
            o_ddr_vpi_req         <= 1'b0;
            o_ddr_vpi_start_addr  <= '0;
            o_ddr_vpi_data_length <= 12'd0;
            o_ddr_req_lose        <= 1'b0;
        end else begin
            syn_v_d        <= i_syn_v;
            row            <= row_nxt;
            frame          <= frame_nxt;
            o_ddr_req_lose <= 1'b0;
            o_ddr_vpi_req  <= (state_nxt == REQ);

            // Line hand-off: a launch frees the pending slot, which a simultaneous new line may refill
            if (launch) begin
                stale                 <= 1'b0;
                o_ddr_vpi_start_addr  <= ADDR_WIDTH'({i_sub_space_num, frame_nxt, row_nxt, 10'd0});
                if (use_pend) begin
                    bank_r                <= pend_bank;
                    numb_r                <= pend_numb;
                    o_ddr_vpi_data_length <= pend_numb;
                    pend_vld              <= line_ok;
                    pend_bank             <= i_line_bank;
                    pend_numb             <= i_write_numb;
                end else begin
                    bank_r                <= i_line_bank;
                    numb_r                <= i_write_numb;
                    o_ddr_vpi_data_length <= i_write_numb;
                    pend_vld              <= 1'b0;
                end
            end else begin
                if (syn_rise && (state != IDLE)) stale <= 1'b1;
                if (line_ok && pend_live) begin
                    o_ddr_req_lose <= 1'b1;
                end else if (line_ok) begin
                    pend_vld  <= 1'b1;
                    pend_bank <= i_line_bank;
                    pend_numb <= i_write_numb;
                end else begin
                    pend_vld  <= pend_live;
                end
            end

            if ((state == REQ) && i_ddr_vpi_ack) beat_cnt <= 12'd0;
            else if (o_ram_rd_en)                beat_cnt <= beat_cnt + 12'd1;

            if (i_ddr_vpi_prio_ini_vld) begin
                prio_base          <= i_ddr_vpi_prio_ini;
                o_ddr_vpi_priority <= i_ddr_vpi_prio_ini;
            end else if ((state == REQ) && i_ddr_vpi_ack) begin
                o_ddr_vpi_priority <= prio_base;
            end else if ((state == REQ) && (o_ddr_vpi_priority != 16'hFFFF)) begin
                o_ddr_vpi_priority <= o_ddr_vpi_priority + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_vpi_chn_wr_ctrl.sv
// Directed bench for ddr3_vpi_chn_wr_ctrl: request/data/done handshakes, priority aging,
// pending/lose handling, frame starts mid-burst, row/frame wrap and both resets.
module tb_ddr3_vpi_chn_wr_ctrl;

    logic         i_sclk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_soft_rst = 1'b0;
    logic         i_syn_v = 1'b0;
    logic         i_line_rdy = 1'b0;
    logic         i_line_bank = 1'b0;
    logic [3:0]   i_sub_space_num = 4'hA;
    logic [11:0]  i_write_numb = 12'd0;
    logic [11:0]  i_start_row_line = 12'd0;
    logic         o_ram_rd_en;
    logic [7:0]   o_ram_rd_addr;
    logic [127:0] i_ram_rd_data = '0;
    logic         o_ddr_vpi_req;
    logic         i_ddr_vpi_ack = 1'b0;
    logic [26:0]  o_ddr_vpi_start_addr;
    logic [11:0]  o_ddr_vpi_data_length;
    logic         i_ddr_vpi_prio_ini_vld = 1'b0;
    logic [15:0]  i_ddr_vpi_prio_ini = 16'h0000;
    logic [15:0]  o_ddr_vpi_priority;
    logic         i_ddr_vpi_wdata_req = 1'b0;
    logic [127:0] o_ddr_vpi_wdata;
    logic         i_ddr_vpi_end = 1'b0;
    logic [1:0]   o_frame_numb;
    logic         o_ddr_req_lose;

    int compares = 0;
    int fails = 0;

    ddr3_vpi_chn_wr_ctrl dut (
        .i_sclk(i_sclk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst), .i_syn_v(i_syn_v),
        .i_line_rdy(i_line_rdy), .i_line_bank(i_line_bank), .i_sub_space_num(i_sub_space_num),
        .i_write_numb(i_write_numb), .i_start_row_line(i_start_row_line),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr), .i_ram_rd_data(i_ram_rd_data),
        .o_ddr_vpi_req(o_ddr_vpi_req), .i_ddr_vpi_ack(i_ddr_vpi_ack),
        .o_ddr_vpi_start_addr(o_ddr_vpi_start_addr), .o_ddr_vpi_data_length(o_ddr_vpi_data_length),
        .i_ddr_vpi_prio_ini_vld(i_ddr_vpi_prio_ini_vld), .i_ddr_vpi_prio_ini(i_ddr_vpi_prio_ini),
        .o_ddr_vpi_priority(o_ddr_vpi_priority), .i_ddr_vpi_wdata_req(i_ddr_vpi_wdata_req),
        .o_ddr_vpi_wdata(o_ddr_vpi_wdata), .i_ddr_vpi_end(i_ddr_vpi_end),
        .o_frame_numb(o_frame_numb), .o_ddr_req_lose(o_ddr_req_lose)
    );

    always #5 i_sclk = ~i_sclk;

    function automatic logic [127:0] ramWord(input logic [7:0] a);
        return {16{a}};
    endfunction

    function automatic logic [26:0] mkAddr(input logic [1:0] fr, input logic [10:0] rw);
        return {4'hA, fr, rw, 10'd0};
    endfunction

    // Line RAM model: one-cycle read latency
    always @(posedge i_sclk) if (o_ram_rd_en) i_ram_rd_data <= ramWord(o_ram_rd_addr);

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic bank, input logic [11:0] numb);
        i_line_rdy   = 1'b1;
        i_line_bank  = bank;
        i_write_numb = numb;
        @(negedge i_sclk);
        i_line_rdy   = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge i_sclk);
    endtask

    task automatic vsyncEdge(input logic [11:0] start_row);
        i_start_row_line = start_row;
        i_syn_v = 1'b1;
        @(negedge i_sclk);
        i_syn_v = 1'b0;
        @(negedge i_sclk);
    endtask

    task automatic grant();
        i_ddr_vpi_ack = 1'b1;
        @(negedge i_sclk);
        i_ddr_vpi_ack = 1'b0;
        checkOutput("req_drop_on_ack", o_ddr_vpi_req, 1'b0);
    endtask

    task automatic pullBeats(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            i_ddr_vpi_wdata_req = 1'b1;
            #1;
            checkOutput("rd_en", o_ram_rd_en, 1'b1);
            checkOutput("rd_addr", o_ram_rd_addr, base + 8'(k));
            @(negedge i_sclk);
            checkOutput("wdata", o_ddr_vpi_wdata, ramWord(base + 8'(k)));
        end
        i_ddr_vpi_wdata_req = 1'b0;
    endtask

    task automatic finishBurst();
        i_ddr_vpi_end = 1'b1;
        @(negedge i_sclk);
        i_ddr_vpi_end = 1'b0;
    endtask

    initial begin
        #1;
        checkOutput("rst_req", o_ddr_vpi_req, 1'b0);
        checkOutput("rst_prio", o_ddr_vpi_priority, 16'h0000);
        checkOutput("rst_frame", o_frame_numb, 2'd0);
        checkOutput("rst_addr", o_ddr_vpi_start_addr, 27'd0);
        checkOutput("rst_lose", o_ddr_req_lose, 1'b0);
        tick(2);
        i_rst_n = 1'b1;
        tick(1);

        $display("[TB] basic line write");
        i_ddr_vpi_prio_ini_vld = 1'b1;
        i_ddr_vpi_prio_ini     = 16'h0010;
        tick(1);
        i_ddr_vpi_prio_ini_vld = 1'b0;
        checkOutput("prio_load", o_ddr_vpi_priority, 16'h0010);
        vsyncEdge(12'd5);
        checkOutput("frame_1", o_frame_numb, 2'd1);
        applyStimulus(1'b0, 12'd4);
        checkOutput("req_1", o_ddr_vpi_req, 1'b1);
        checkOutput("addr_1", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd5));
        checkOutput("len_1", o_ddr_vpi_data_length, 12'd4);
        grant();
        pullBeats(8'h00, 4);
        finishBurst();
        checkOutput("idle_after_1", o_ddr_vpi_req, 1'b0);

        $display("[TB] priority aging");
        applyStimulus(1'b1, 12'd2);
        checkOutput("addr_row6", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd6));
        checkOutput("prio_start", o_ddr_vpi_priority, 16'h0010);
        tick(20);
        checkOutput("prio_aged", o_ddr_vpi_priority, 16'h0024);
        checkOutput("req_held", o_ddr_vpi_req, 1'b1);
        grant();
        checkOutput("prio_restored", o_ddr_vpi_priority, 16'h0010);
        pullBeats(8'h80, 2);
        finishBurst();
        i_ddr_vpi_prio_ini_vld = 1'b1;
        i_ddr_vpi_prio_ini     = 16'hFFF0;
        tick(1);
        i_ddr_vpi_prio_ini_vld = 1'b0;
        applyStimulus(1'b0, 12'd1);
        checkOutput("addr_row7", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd7));
        tick(40);
        checkOutput("prio_sat", o_ddr_vpi_priority, 16'hFFFF);
        grant();
        checkOutput("prio_base_fff0", o_ddr_vpi_priority, 16'hFFF0);
        pullBeats(8'h00, 1);
        finishBurst();

        $display("[TB] pending and lose");
        applyStimulus(1'b0, 12'd3);
        checkOutput("addr_row8", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd8));
        applyStimulus(1'b1, 12'd2);
        checkOutput("pend_no_lose", o_ddr_req_lose, 1'b0);
        applyStimulus(1'b0, 12'd1);
        checkOutput("lose_pulse", o_ddr_req_lose, 1'b1);
        tick(1);
        checkOutput("lose_one_cycle", o_ddr_req_lose, 1'b0);
        grant();
        pullBeats(8'h00, 3);
        finishBurst();
        checkOutput("pend_req", o_ddr_vpi_req, 1'b1);
        checkOutput("pend_addr", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd9));
        checkOutput("pend_len", o_ddr_vpi_data_length, 12'd2);
        grant();
        pullBeats(8'h80, 2);
        finishBurst();
        checkOutput("no_third", o_ddr_vpi_req, 1'b0);

        $display("[TB] frame start mid-burst");
        applyStimulus(1'b0, 12'd4);
        checkOutput("addr_row10", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd10));
        applyStimulus(1'b1, 12'd3);
        grant();
        pullBeats(8'h00, 2);
        vsyncEdge(12'd100);
        checkOutput("frame_2", o_frame_numb, 2'd2);
        checkOutput("addr_kept", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd10));
        pullBeats(8'h02, 2);
        finishBurst();
        checkOutput("pend_dropped", o_ddr_vpi_req, 1'b0);
        checkOutput("drop_no_lose", o_ddr_req_lose, 1'b0);
        applyStimulus(1'b0, 12'd1);
        checkOutput("addr_new_frame", o_ddr_vpi_start_addr, mkAddr(2'd2, 11'd100));
        grant();
        pullBeats(8'h00, 1);
        finishBurst();
        vsyncEdge(12'd2047);
        vsyncEdge(12'd2047);
        checkOutput("frame_wrap", o_frame_numb, 2'd0);

        $display("[TB] full line and row wrap");
        applyStimulus(1'b0, 12'd128);
        checkOutput("addr_row2047", o_ddr_vpi_start_addr, mkAddr(2'd0, 11'd2047));
        checkOutput("len_128", o_ddr_vpi_data_length, 12'd128);
        grant();
        pullBeats(8'h00, 128);
        i_ddr_vpi_wdata_req = 1'b1;
        #1;
        checkOutput("no_rd_wait_end", o_ram_rd_en, 1'b0);
        @(negedge i_sclk);
        i_ddr_vpi_wdata_req = 1'b0;
        finishBurst();
        applyStimulus(1'b0, 12'd1);
        checkOutput("addr_row0", o_ddr_vpi_start_addr, mkAddr(2'd0, 11'd0));
        grant();
        pullBeats(8'h00, 1);
        finishBurst();
        applyStimulus(1'b1, 12'd0);
        checkOutput("numb0_no_req", o_ddr_vpi_req, 1'b0);
        checkOutput("numb0_no_lose", o_ddr_req_lose, 1'b0);

        $display("[TB] resets mid-burst");
        vsyncEdge(12'd300);
        applyStimulus(1'b0, 12'd4);
        checkOutput("addr_row300", o_ddr_vpi_start_addr, mkAddr(2'd1, 11'd300));
        grant();
        pullBeats(8'h00, 2);
        i_ddr_vpi_wdata_req = 1'b1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("hrst_rd_en", o_ram_rd_en, 1'b0);
        checkOutput("hrst_frame", o_frame_numb, 2'd0);
        checkOutput("hrst_prio", o_ddr_vpi_priority, 16'h0000);
        @(negedge i_sclk);
        i_ddr_vpi_wdata_req = 1'b0;
        i_rst_n = 1'b1;
        tick(1);
        applyStimulus(1'b0, 12'd1);
        checkOutput("hrst_next_addr", o_ddr_vpi_start_addr, mkAddr(2'd0, 11'd0));
        grant();
        pullBeats(8'h00, 1);
        finishBurst();
        vsyncEdge(12'd300);
        applyStimulus(1'b1, 12'd4);
        grant();
        pullBeats(8'h80, 2);
        i_soft_rst = 1'b1;
        @(negedge i_sclk);
        i_soft_rst = 1'b0;
        i_ddr_vpi_wdata_req = 1'b1;
        #1;
        checkOutput("srst_rd_en", o_ram_rd_en, 1'b0);
        checkOutput("srst_req", o_ddr_vpi_req, 1'b0);
        checkOutput("srst_frame", o_frame_numb, 2'd0);
        @(negedge i_sclk);
        i_ddr_vpi_wdata_req = 1'b0;
        applyStimulus(1'b0, 12'd2);
        checkOutput("srst_next_req", o_ddr_vpi_req, 1'b1);
        checkOutput("srst_next_addr", o_ddr_vpi_start_addr, mkAddr(2'd0, 11'd0));
        grant();
        pullBeats(8'h00, 2);
        finishBurst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
